ycocg_block_buffer: RTL

- Sits directly downstream of the encoder's RGB-to-YCoCg colour conversion stage.
- Collects the converted signed 14-bit Y/Co/Cg pixels of one 8x2 block into a ping-pong (double) buffer.
- Presents each complete block as one wide parallel word to the block-level coding stages, with valid/ready handshakes on both sides.
- Pixels arrive in block order: row 0 columns 0..7, then row 1 columns 0..7.

---
 rtl/ycocg_block_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/ycocg_block_buffer.sv
// Ping-pong collector for 8x2 blocks of signed Y/Co/Cg pixels.
// One bank fills pixel by pixel while the other presents a whole block as a wide word.
module ycocg_block_buffer #(
    parameter int BITS             = 14,
    parameter int BLOCK_PIX        = 16,
    parameter int BLOCKS_PER_SLICE = 240
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BITS-1:0]      in_y,
    input  logic signed [BITS-1:0]      in_co,
    input  logic signed [BITS-1:0]      in_cg,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BITS*BLOCK_PIX-1:0]   out_y,
    output logic [BITS*BLOCK_PIX-1:0]   out_co,
    output logic [BITS*BLOCK_PIX-1:0]   out_cg,
    output logic                        out_last
);

    localparam int IDX_W = $clog2(BLOCK_PIX);
    localparam int SEL_W = IDX_W + 1;
    localparam int NSLOT = 2 * BLOCK_PIX;
    localparam int CNT_W = (BLOCKS_PER_SLICE > 1) ? $clog2(BLOCKS_PER_SLICE) : 1;

    // Both banks live in one flat array; the bank number is the top address bit.
    logic [BITS-1:0]  r_y  [NSLOT];
    logic [BITS-1:0]  r_co [NSLOT];
    logic [BITS-1:0]  r_cg [NSLOT];

    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_rd_bank;
    logic [1:0]       r_full;
    logic [CNT_W-1:0] r_blk_cnt;

    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_last_pix;
    logic [SEL_W-1:0] w_wr_sel;
    logic [1:0]       w_full_next;

    assign in_ready   = !r_full[r_wr_bank] && !rst;
    assign out_valid  = r_full[r_rd_bank];
    assign out_last   = (r_blk_cnt == CNT_W'(BLOCKS_PER_SLICE - 1));

    assign w_wr_fire  = in_valid && in_ready;
    assign w_rd_fire  = out_valid && out_ready && !rst;
    assign w_last_pix = (r_wr_idx == IDX_W'(BLOCK_PIX - 1));
    assign w_wr_sel   = {r_wr_bank, r_wr_idx};

    // A completing write and a release always target different banks.
    always_comb begin
        w_full_next = r_full;
        if (w_rd_fire) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_wr_fire && w_last_pix) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_y[i]  <= '0;
                r_co[i] <= '0;
                r_cg[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_y[w_wr_sel]  <= in_y;
            r_co[w_wr_sel] <= in_co;
            r_cg[w_wr_sel] <= in_cg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_rd_bank <= 1'b0;
            r_full    <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_wr_fire) begin
                if (w_last_pix) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= !r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + IDX_W'(1);
                end
            end
            if (w_rd_fire) begin
                r_rd_bank <= !r_rd_bank;
                if (out_last) begin
                    r_blk_cnt <= '0;
                end else begin
                    r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_PIX; gi++) begin : g_pack
            assign out_y[BITS*gi +: BITS]  = r_y[{r_rd_bank, IDX_W'(gi)}];
            assign out_co[BITS*gi +: BITS] = r_co[{r_rd_bank, IDX_W'(gi)}];
            assign out_cg[BITS*gi +: BITS] = r_cg[{r_rd_bank, IDX_W'(gi)}];
        end
    endgenerate

endmodule
